gcd_req_queue: RTL and testbench

GCD_REQ_QUEUE -- requirements
Module: gcd_req_queue

---
 rtl/gcd_req_queue.sv | 83 ++++++++
 tb/tb_gcd_req_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gcd_req_queue.sv
// Circular operand-pair queue feeding the GCD unit (valid/ready both sides).
// Optional same-cycle empty-queue bypass enabled by defining GCD_REQ_QUEUE_BYPASS_EN.
module gcd_req_queue #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enq_val,
   output logic                     enq_rdy,
   input  logic [2*DATA_W-1:0]      enq_msg,
   output logic                     deq_val,
   input  logic                     deq_rdy,
   output logic [2*DATA_W-1:0]      deq_msg,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [2*DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_enq;
   logic w_deq;
   logic w_write;
   logic w_read;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);
   assign enq_rdy = !reset && !w_full;
   assign w_enq   = enq_val && enq_rdy;
   assign w_deq   = deq_val && deq_rdy;
   assign count   = r_count;

`ifdef GCD_REQ_QUEUE_BYPASS_EN
   logic w_bypass_xfer;

   // Empty queue forwards the incoming pair; a taken bypass never touches storage.
   assign deq_val       = !reset && (w_empty ? enq_val : 1'b1);
   assign deq_msg       = w_empty ? enq_msg : r_mem[r_rd_ptr];
   assign w_bypass_xfer = w_empty && w_enq && w_deq;
   assign w_write       = w_enq && !w_bypass_xfer;
   assign w_read        = w_deq && !w_bypass_xfer;
`else
   assign deq_val = !reset && !w_empty;
   assign deq_msg = r_mem[r_rd_ptr];
   assign w_write = w_enq;
   assign w_read  = w_deq;
`endif

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= enq_msg;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_read) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_write, w_read})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_req_queue.sv
// Directed + random bench for gcd_req_queue; a scoreboard queue holds pairs in
// enqueue order and each dequeue is checked against its head.
module tb_gcd_req_queue;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 4;
`ifdef GCD_REQ_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                  clk;
   logic                  reset;
   logic                  enq_val;
   logic                  enq_rdy;
   logic [2*DATA_W-1:0]   enq_msg;
   logic                  deq_val;
   logic                  deq_rdy;
   logic [2*DATA_W-1:0]   deq_msg;
   logic [$clog2(DEPTH):0] count;

   int unsigned n_checks;
   int unsigned n_fails;
   int unsigned m_count;
   logic [31:0] sb[$];
   logic [31:0] seq_val;

   gcd_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .enq_val (enq_val),
      .enq_rdy (enq_rdy),
      .enq_msg (enq_msg),
      .deq_val (deq_val),
      .deq_rdy (deq_rdy),
      .deq_msg (deq_msg),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs against the model, advance model and clock.
   task automatic step(input logic ev, input logic [31:0] msg, input logic dr);
      logic mdv;
      logic [31:0] mmsg;
      logic menq;
      logic mdeq;
      enq_val = ev;
      enq_msg = msg;
      deq_rdy = dr;
      #1;
      mdv  = (m_count > 0) || (BYP && ev && m_count == 0);
      mmsg = (m_count > 0) ? sb[0] : msg;
      check("count",   32'(count),   m_count);
      check("enq_rdy", 32'(enq_rdy), 32'(m_count < DEPTH));
      check("deq_val", 32'(deq_val), 32'(mdv));
      if (mdv) check("deq_msg", deq_msg, mmsg);
      menq = ev && (m_count < DEPTH);
      mdeq = mdv && dr;
      if (menq && mdeq && m_count == 0) begin
         // bypass transfer: nothing stored
      end else begin
         if (mdeq) begin
            void'(sb.pop_front());
            m_count--;
         end
         if (menq) begin
            sb.push_back(msg);
            m_count++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int unsigned cycles);
      reset = 1'b1;
      enq_val = 1'b1;
      enq_msg = 32'hDEAD_BEEF;
      deq_rdy = 1'b1;
      for (int unsigned i = 0; i < cycles; i++) begin
         #1;
         check("rst_enq_rdy", 32'(enq_rdy), 32'd0);
         check("rst_deq_val", 32'(deq_val), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      enq_val = 1'b0;
      deq_rdy = 1'b0;
      m_count = 0;
      sb.delete();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      m_count  = 0;
      reset    = 1'b1;
      enq_val  = 1'b0;
      enq_msg  = '0;
      deq_rdy  = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);

      // single enqueue, visible next cycle
      step(1'b1, 32'h000F_0005, 1'b0);
      check("req028_msg", deq_msg, 32'h000F_0005);
      step(1'b0, 32'h0, 1'b0);

      // fill to full, reject fifth, drain in order
      step(1'b1, 32'h0001_0011, 1'b0);
      step(1'b1, 32'h0002_0022, 1'b0);
      step(1'b1, 32'h0003_0033, 1'b0);
      step(1'b1, 32'h0004_0044, 1'b0);
      step(1'b1, 32'h0005_0055, 1'b1);
      for (int unsigned i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

      // steady state at count 2 with pointer wrap
      step(1'b1, 32'h0010_0001, 1'b0);
      step(1'b1, 32'h0010_0002, 1'b0);
      for (int unsigned i = 0; i < 6; i++) step(1'b1, 32'h0020_0000 + i, 1'b1);
      for (int unsigned i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);

      // reset discards stored entries
      step(1'b1, 32'h0030_0001, 1'b0);
      step(1'b1, 32'h0030_0002, 1'b0);
      step(1'b1, 32'h0030_0003, 1'b0);
      do_reset(1);
      step(1'b1, 32'h0023_0007, 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);

      // empty queue with enq and deq in the same cycle
      step(1'b1, 32'h0009_0003, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b0);

      // consumer that stalls while busy: deq_msg must hold
      seq_val = 32'h1000_0000;
      for (int unsigned i = 0; i < 300; i++) begin
         logic ev;
         logic dr;
         ev = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 2) == 0);
         step(ev, seq_val, dr);
         if (ev) seq_val = seq_val + 32'h0001_0003;
      end
      for (int unsigned i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
